pipe_stage_reg: RTL

Parametrised pipeline boundary register that generalises the per-stage control/data latches between decode and execute, and is reusable at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It captures a configurable number of data channels, register-index fields and a control vector, all tagged with a valid bit. It supports stall (hold), flush (bubble insertion) and a sticky halt latch, and it keeps saturating stall/bubble counters for hazard-unit debug.

---
 rtl/pipe_stage_reg.sv | 93 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: valid-tagged payload with stall/flush/halt
// control and saturating stall/bubble counters for hazard-unit debug.
module pipe_stage_reg #(
  parameter int DATA_W   = 16,
  parameter int NUM_DATA = 2,
  parameter int IDX_W    = 4,
  parameter int NUM_IDX  = 3,
  parameter int CTRL_W   = 8,
  parameter int HALT_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         clr_cnt,
  input  logic                         in_valid,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic [NUM_IDX*IDX_W-1:0]     in_idx,
  output logic                         out_valid,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [NUM_IDX*IDX_W-1:0]     out_idx,
  output logic                         halted,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             bubble_cnt
);

  logic do_capture;
  logic do_stall;
  logic do_bubble;

  // Decode this edge's action: flush beats stall beats load.
  always_comb begin
    do_capture = 1'b0;
    do_stall   = 1'b0;
    do_bubble  = 1'b0;
    if (flush) begin
      do_bubble = 1'b1;
    end else if (stall) begin
      do_stall = 1'b1;
    end else if (in_valid && !halted) begin
      do_capture = 1'b1;
    end else begin
      do_bubble = 1'b1;
    end
  end

  // Payload, valid and sticky halt latch; bubbles are fully zeroed so
  // downstream sees index 0 and inactive control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      halted    <= 1'b0;
    end else if (do_capture) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
      out_idx   <= in_idx;
      if (in_ctrl[HALT_BIT]) begin
        halted <= 1'b1;
      end
    end else if (do_bubble) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
      out_idx   <= '0;
    end
  end

  // Saturating debug counters; clear wins over any increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (do_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (do_bubble && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule
